// File: rtl/calc_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared keypad codes and controller state encoding for the
//            BCD calculator sequencer (optional build macro: CALC_TIMEOUT_EN).
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Keypad digits are the codes 0..9; everything above is a command or unused.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl_if
// Purpose  : Keypad / ALU handshake bundle of the calculator sequencer.
//            master = environment (keypad + ALU), slave = controller.
// Revision : 1.0 - initial release
// ============================================================================
interface calc_seq_ctrl_if #(
  parameter int MAX_DIGITS = 2
);
  localparam int W = 4 * MAX_DIGITS;

  logic [3:0]   key_code;
  logic         key_valid;
  logic         alu_done;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         add_sub;
  logic         alu_start;
  logic         busy;
  logic         show_result;
  logic         entry;
  logic         error;

  modport master (
    output key_code, key_valid, alu_done,
    input  operand_a, operand_b, add_sub, alu_start, busy, show_result, entry, error
  );

  modport slave (
    input  key_code, key_valid, alu_done,
    output operand_a, operand_b, add_sub, alu_start, busy, show_result, entry, error
  );

endinterface
`default_nettype wire

// File: rtl/calc_seq_ctrl_bcd_entry_reg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_reg
// Purpose  : Shift-in BCD operand register with digit count and full flag.
//            Clear has priority; clear together with shift loads the digit
//            as the first digit of a fresh operand.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_entry_reg #(
  parameter int MAX_DIGITS = 2
) (
  input  wire logic                                clk,
  input  wire logic                                rst_n,
  input  wire logic                                i_clr,
  input  wire logic                                i_shift,
  input  wire logic [3:0]                          i_digit,
  output logic      [4*MAX_DIGITS-1:0]             o_value,
  output logic      [$clog2(MAX_DIGITS+1)-1:0]     o_count,
  output logic                                     o_full
);

  localparam int W  = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] c_MAX = CW'(MAX_DIGITS);

  logic [W-1:0]  r_value;
  logic [CW-1:0] r_count;

  assign o_value = r_value;
  assign o_count = r_count;
  assign o_full  = (r_count == c_MAX);

  // Operand shift register: clear/reload, or shift one digit in while not full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      if (i_shift) begin
        r_value <= W'(i_digit);
        r_count <= CW'(1);
      end else begin
        r_value <= '0;
        r_count <= '0;
      end
    end else if (i_shift && !o_full) begin
      r_value <= (r_value << 4) | W'(i_digit);
      r_count <= r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_seq_ctrl
// Purpose  : Keypad-driven sequencer for a BCD add/subtract calculator.
//            Collects two operands, launches the ALU, waits for completion
//            and selects the result for display.
//            Build macro CALC_TIMEOUT_EN adds a WAIT watchdog and ERROR state.
// Revision : 1.0 - initial release
// ============================================================================
module calc_seq_ctrl #(
  parameter int MAX_DIGITS  = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  wire logic      clock,
  input  wire logic      clearA,
  calc_seq_ctrl_if.slave bus
);

  import calc_pkg::*;

  localparam int W  = 4 * MAX_DIGITS;
  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_add_sub;
  logic          w_add_sub_nxt;
  logic          w_clr_a, w_clr_b, w_shift_a, w_shift_b, w_clear_all;
  logic [CW-1:0] w_cnt_a, w_cnt_b;
  logic          w_full_a, w_full_b;
  logic [W-1:0]  w_op_a, w_op_b;
  logic          w_is_dig, w_is_op, w_timeout;

  assign w_is_dig = is_digit(bus.key_code);
  assign w_is_op  = (bus.key_code == KEY_ADD) || (bus.key_code == KEY_SUB);

  bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_reg_a (
    .clk     (clock),
    .rst_n   (clearA),
    .i_clr   (w_clr_a),
    .i_shift (w_shift_a),
    .i_digit (bus.key_code),
    .o_value (w_op_a),
    .o_count (w_cnt_a),
    .o_full  (w_full_a)
  );

  bcd_entry_reg #(.MAX_DIGITS(MAX_DIGITS)) u_reg_b (
    .clk     (clock),
    .rst_n   (clearA),
    .i_clr   (w_clr_b),
    .i_shift (w_shift_b),
    .i_digit (bus.key_code),
    .o_value (w_op_b),
    .o_count (w_cnt_b),
    .o_full  (w_full_b)
  );

`ifdef CALC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;

  // Watchdog: counts cycles spent in WAIT, held at zero in every other state
  always_ff @(posedge clock) begin
    if (!clearA || (r_state != ST_WAIT)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign w_timeout = (r_state == ST_WAIT) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
  assign bus.error = (r_state == ST_ERROR);
`else
  assign w_timeout = 1'b0;
  assign bus.error = 1'b0;
`endif

  // State and operation-select registers
  always_ff @(posedge clock) begin
    if (!clearA) begin
      r_state   <= ST_ENTER_A;
      r_add_sub <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_add_sub <= w_add_sub_nxt;
    end
  end

  // Next-state decode and operand register controls
  always_comb begin
    w_state_nxt   = r_state;
    w_add_sub_nxt = r_add_sub;
    w_clr_a       = 1'b0;
    w_clr_b       = 1'b0;
    w_shift_a     = 1'b0;
    w_shift_b     = 1'b0;
    w_clear_all   = 1'b0;
    case (r_state)
      ST_ENTER_A: begin
        if (bus.key_valid) begin
          if (w_is_dig) begin
            w_shift_a = !w_full_a;
          end else if (w_is_op && (w_cnt_a != '0)) begin
            w_add_sub_nxt = (bus.key_code == KEY_SUB);
            w_state_nxt   = ST_ENTER_B;
          end else if (bus.key_code == KEY_CLR) begin
            w_clear_all = 1'b1;
          end
        end
      end
      ST_ENTER_B: begin
        if (bus.key_valid) begin
          if (w_is_dig) begin
            w_shift_b = !w_full_b;
          end else if (w_is_op) begin
            w_add_sub_nxt = (bus.key_code == KEY_SUB);
          end else if ((bus.key_code == KEY_EQ) && (w_cnt_b != '0)) begin
            w_state_nxt = ST_EXEC;
          end else if (bus.key_code == KEY_CLR) begin
            w_clear_all = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // Keys are dropped here; completion wins over a same-cycle timeout
        if (bus.alu_done) begin
          w_state_nxt = ST_SHOW;
        end else if (w_timeout) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_SHOW: begin
        if (bus.key_valid) begin
          if (w_is_dig) begin
            // New calculation: wipe both operands, digit becomes A's first digit
            w_clr_a     = 1'b1;
            w_clr_b     = 1'b1;
            w_shift_a   = 1'b1;
            w_state_nxt = ST_ENTER_A;
          end else if (bus.key_code == KEY_CLR) begin
            w_clear_all = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        if (bus.key_valid && (bus.key_code == KEY_CLR)) begin
          w_clear_all = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_ENTER_A;
      end
    endcase
    if (w_clear_all) begin
      w_clr_a       = 1'b1;
      w_clr_b       = 1'b1;
      w_add_sub_nxt = 1'b0;
      w_state_nxt   = ST_ENTER_A;
    end
  end

  assign bus.operand_a   = w_op_a;
  assign bus.operand_b   = w_op_b;
  assign bus.add_sub     = r_add_sub;
  assign bus.alu_start   = (r_state == ST_EXEC);
  assign bus.busy        = (r_state == ST_EXEC) || (r_state == ST_WAIT);
  assign bus.show_result = (r_state == ST_SHOW);
  assign bus.entry       = (r_state == ST_ENTER_A) || (r_state == ST_ENTER_B) ||
                           (r_state == ST_SHOW)    || (r_state == ST_ERROR);

endmodule
`default_nettype wire
